// File: rtl/dijkstra_pkg.sv
// Shared definitions for the Dijkstra datapath.
//   - relaxer_state_t : state encoding of the edge relaxer FSM
//   - NO_EDGE         : edge weight value meaning "no edge between the nodes"
//   - inf_value()     : all-ones "infinite distance" for a given value width
// Default table geometry comes from DEFAULT_MAX_NODES, DEFAULT_INDEX_WIDTH and
// DEFAULT_VALUE_WIDTH. Each one can be overridden on the command line.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif

package dijkstra_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_UPDATE = 3'd5,
    ST_DONE   = 3'd6
  } relaxer_state_t;

  localparam int NO_EDGE = 0;

  // All-ones value of the given width (width <= 64); callers cast to their width.
  function automatic logic [63:0] inf_value(input int width);
    return {64{1'b1}} >> (64 - width);
  endfunction

endpackage

// File: rtl/relax_alu.sv
// Combinational relaxation arithmetic.
//   base_dist   : dist[u]
//   edge_weight : w(u,v), NO_EDGE means there is no edge
//   old_dist    : current dist[v]
//   new_dist    : dist[u] + w, saturated to INF (all ones)
//   do_update   : edge present, dist[u] finite, and the new distance strictly smaller
// The caller still has to exclude v == u and nodes that are already visited.
module relax_alu
  import dijkstra_pkg::*;
#(
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) (
  input  logic [VALUE_WIDTH-1:0] base_dist,
  input  logic [VALUE_WIDTH-1:0] edge_weight,
  input  logic [VALUE_WIDTH-1:0] old_dist,
  output logic [VALUE_WIDTH-1:0] new_dist,
  output logic                   do_update
);

  localparam logic [VALUE_WIDTH-1:0] INF = VALUE_WIDTH'(inf_value(VALUE_WIDTH));

  logic [VALUE_WIDTH:0] sum;

  always_comb begin
    // The extra bit keeps the carry, so an overflowing sum saturates instead of wrapping.
    sum = {1'b0, base_dist} + {1'b0, edge_weight};
    if (sum >= {1'b0, INF}) begin
      new_dist = INF;
    end else begin
      new_dist = sum[VALUE_WIDTH-1:0];
    end
    // The compare is strict. On a tie the old predecessor is kept. A saturated sum
    // can never win, because no stored distance is larger than INF.
    do_update = (edge_weight != VALUE_WIDTH'(NO_EDGE)) && (base_dist != INF) &&
                (new_dist < old_dist);
  end

endmodule

// File: rtl/edge_relaxer.sv
// Edge relaxer: the stage after EdgeCache in the Dijkstra datapath.
// It owns the dist/prev/visited tables.
// - init  : clears the tables over N cycles. Each entry gets dist = INF,
//           prev = own index and visited = 0. The source entry gets dist = 0.
// - start : walks v = 0..N-1 for node u and relaxes dist[v] through edge(u,v).
// Ports:
//   clock, reset (async, active-high)
//   init, source_node, number_of_nodes   table initialisation request
//   start, current_node                  relaxation request for node u
//   busy, done                           status; done pulses for one cycle
//   query_enable, from_node, to_node     request to EdgeCache
//   edge_ready, edge_value               response from EdgeCache
//   rd_node -> rd_dist, rd_prev, rd_visited  combinational table read port
//   fsm_state                            current FSM state, for observation
// Compile option EDGE_RELAXER_SKIP_VISITED_EN: when defined, ISSUE does not query
// EdgeCache for v == u or for nodes already visited. These take one cycle each.
// The table results are the same either way.
//
// EdgeCache handshake: query_enable is the request valid. from_node and to_node
// stay stable while it is high. It stays high until edge_ready is sampled high,
// and edge_value is captured on that same edge. query_enable then drops for at
// least one cycle (UPDATE) before the next request.
module edge_relaxer
  import dijkstra_pkg::*;
#(
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   init,
  input  logic [INDEX_WIDTH-1:0] source_node,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] current_node,
  output logic                   busy,
  output logic                   done,
  output logic                   query_enable,
  output logic [INDEX_WIDTH-1:0] from_node,
  output logic [INDEX_WIDTH-1:0] to_node,
  input  logic                   edge_ready,
  input  logic [VALUE_WIDTH-1:0] edge_value,
  input  logic [INDEX_WIDTH-1:0] rd_node,
  output logic [VALUE_WIDTH-1:0] rd_dist,
  output logic [INDEX_WIDTH-1:0] rd_prev,
  output logic                   rd_visited,
  output relaxer_state_t         fsm_state
);

  localparam logic [VALUE_WIDTH-1:0] INF = VALUE_WIDTH'(inf_value(VALUE_WIDTH));

  relaxer_state_t state, state_next;

  logic [INDEX_WIDTH-1:0] u_q, v_q, src_q, last_q, int_addr;
  logic [VALUE_WIDTH-1:0] du_q, w_q, int_dist, new_dist;
  logic                   int_visited, do_update, relax_write, skip, v_last;

  logic [VALUE_WIDTH-1:0] dist_tbl    [MAX_NODES];
  logic [INDEX_WIDTH-1:0] prev_tbl    [MAX_NODES];
  logic                   visited_tbl [MAX_NODES];

  // Converts a node count into the index of the last entry. A count of 0 is
  // treated as 1. A count larger than the table is clamped to the table depth.
  function automatic logic [INDEX_WIDTH-1:0] last_of(input logic [INDEX_WIDTH-1:0] n);
    if (n == '0) return '0;
    if (int'(n) > MAX_NODES) return INDEX_WIDTH'(MAX_NODES - 1);
    return n - INDEX_WIDTH'(1);
  endfunction

  // Internal read port. LOAD needs dist[u]; every other state looks at entry v.
  assign int_addr    = (state == ST_LOAD) ? u_q : v_q;
  assign int_dist    = dist_tbl[int_addr];
  assign int_visited = visited_tbl[int_addr];

  // External read port, used by the min-distance selector.
  assign rd_dist    = dist_tbl[rd_node];
  assign rd_prev    = prev_tbl[rd_node];
  assign rd_visited = visited_tbl[rd_node];

  assign v_last = (v_q == last_q);

`ifdef EDGE_RELAXER_SKIP_VISITED_EN
  assign skip = (state == ST_ISSUE) && ((v_q == u_q) || int_visited);
`else
  assign skip = 1'b0;
`endif

  relax_alu #(
    .VALUE_WIDTH(VALUE_WIDTH)
  ) u_alu (
    .base_dist  (du_q),
    .edge_weight(w_q),
    .old_dist   (int_dist),
    .new_dist   (new_dist),
    .do_update  (do_update)
  );

  assign relax_write = (state == ST_UPDATE) && do_update && (v_q != u_q) && !int_visited;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = ST_LOAD;
        else       state_next = ST_IDLE;
      end
      ST_INIT:   if (v_last) state_next = ST_DONE;
      ST_LOAD:   state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (skip) state_next = v_last ? ST_DONE : ST_ISSUE;
        else      state_next = ST_WAIT;
      end
      ST_WAIT:   if (edge_ready) state_next = ST_UPDATE;
      ST_UPDATE: state_next = v_last ? ST_DONE : ST_ISSUE;
      default:   state_next = ST_IDLE;
    endcase
    // init is accepted in any state. It aborts a relax pass that is in progress.
    if (init) state_next = ST_INIT;
  end

  assign busy         = (state != ST_IDLE) && (state != ST_DONE);
  assign done         = (state == ST_DONE);
  assign query_enable = (state == ST_WAIT) || ((state == ST_ISSUE) && !skip);
  assign from_node    = u_q;
  assign to_node      = v_q;
  assign fsm_state    = state;

  // Datapath registers. v_q also serves as the entry counter during INIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      u_q    <= '0;
      v_q    <= '0;
      src_q  <= '0;
      last_q <= '0;
      du_q   <= '0;
      w_q    <= '0;
    end else if (init) begin
      src_q  <= source_node;
      last_q <= last_of(number_of_nodes);
      v_q    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            u_q <= current_node;
            v_q <= '0;
          end
        end
        ST_INIT, ST_UPDATE: v_q <= v_last ? '0 : v_q + INDEX_WIDTH'(1);
        ST_LOAD:  du_q <= int_dist;
        ST_ISSUE: if (skip) v_q <= v_last ? '0 : v_q + INDEX_WIDTH'(1);
        ST_WAIT:  if (edge_ready) w_q <= edge_value;
        default: ;
      endcase
    end
  end

  // Table writes. The tables have no reset and keep their contents across a reset.
  always_ff @(posedge clock) begin
    if (state == ST_INIT) begin
      dist_tbl[v_q]    <= (v_q == src_q) ? '0 : INF;
      prev_tbl[v_q]    <= v_q;
      visited_tbl[v_q] <= 1'b0;
    end
    if (state == ST_LOAD) begin
      visited_tbl[u_q] <= 1'b1;
    end
    if (relax_write) begin
      dist_tbl[v_q] <= new_dist;
      prev_tbl[v_q] <= u_q;
    end
  end

endmodule

// File: tb/tb_edge_relaxer.sv
// Bench for edge_relaxer with N = 4 and 16-bit values.
// The EdgeCache model returns edge(r,c) = 256*r + c + 1 after a random latency of
// 1..5 cycles. Two mode flags change individual edges. Each relax pass queues the
// (u,v) queries it expects; the model pops one entry per handshake.
module tb_edge_relaxer;
  import dijkstra_pkg::*;

  localparam int MAX_NODES = 16;
  localparam int IW        = 4;
  localparam int VW        = 16;
  localparam int N         = 4;
  localparam logic [VW-1:0] INF = 16'hFFFF;

  logic          clock, reset, init, start, edge_ready;
  logic [IW-1:0] source_node, number_of_nodes, current_node, rd_node;
  logic [VW-1:0] edge_value;
  logic          busy, done, query_enable, rd_visited;
  logic [IW-1:0] from_node, to_node, rd_prev;
  logic [VW-1:0] rd_dist;
  relaxer_state_t fsm_state;

  edge_relaxer #(
    .MAX_NODES(MAX_NODES), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW)
  ) dut (
    .clock(clock), .reset(reset), .init(init), .source_node(source_node),
    .number_of_nodes(number_of_nodes), .start(start), .current_node(current_node),
    .busy(busy), .done(done), .query_enable(query_enable), .from_node(from_node),
    .to_node(to_node), .edge_ready(edge_ready), .edge_value(edge_value),
    .rd_node(rd_node), .rd_dist(rd_dist), .rd_prev(rd_prev), .rd_visited(rd_visited),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / EdgeCache model ----------------
  logic [2*IW-1:0] exp_q[$];
  int hs_cnt   = 0;
  int done_cnt = 0;
  int lat_sum  = 0;
  bit zero_mode = 1'b0;
  bit sat_mode  = 1'b0;

  function automatic logic [VW-1:0] edge_w(input logic [IW-1:0] r, input logic [IW-1:0] c);
    if (zero_mode && r == 0 && c == 2) return '0;
    if (sat_mode && r == 0 && c == 1) return 16'hFFFE;
    if (sat_mode && r == 1 && c == 3) return 16'd5;
    return VW'(256 * int'(r) + int'(c) + 1);
  endfunction

  initial begin : edge_cache
    bit              pending;
    bit              prev_qe;
    int              remaining;
    logic [2*IW-1:0] exp_entry;
    pending    = 1'b0;
    prev_qe    = 1'b0;
    remaining  = 0;
    edge_ready = 1'b0;
    edge_value = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pending    = 1'b0;
        edge_ready = 1'b0;
      end else if (edge_ready) begin
        edge_ready = 1'b0;
        pending    = 1'b0;
      end else if (pending) begin
        remaining--;
        if (remaining == 0) begin
          edge_value = edge_w(from_node, to_node);
          edge_ready = 1'b1;
          if (query_enable) begin
            hs_cnt++;
            check_eq("hs_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              exp_entry = exp_q.pop_front();
              check_eq("hs_from_to", {from_node, to_node}, exp_entry);
            end
          end
        end
      end else if (query_enable) begin
        // A new query must follow at least one cycle with query_enable low.
        check_eq("qe_low_gap", prev_qe, 0);
        pending   = 1'b1;
        remaining = $urandom_range(1, 5);
        lat_sum  += remaining;
      end
      prev_qe = query_enable;
    end
  end

  initial begin : done_monitor
    forever begin
      @(negedge clock);
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_init(input int src, input int n, input int exp_lat);
    int edges;
    source_node     = IW'(src);
    number_of_nodes = IW'(n);
    init  = 1'b1;
    edges = 0;
    do begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      init = 1'b0;
      if (edges == 1) begin
        check_eq("init_busy", busy, 1);
        check_eq("init_qe_low", query_enable, 0);
      end
    end while (!done && edges < 200);
    check_eq("init_latency", edges, exp_lat);
    @(negedge clock);
    check_eq("init_done_pulse", done, 0);
  endtask

  // Runs one relax pass from u. With poke set, a second start for node 3 is pulsed
  // mid-pass; the DUT must ignore it.
  task automatic do_start(input int u, input bit poke);
    int edges;
    int d0;
    bit seen;
    for (int v = 0; v < N; v++) exp_q.push_back({IW'(u), IW'(v)});
    lat_sum      = 0;
    d0           = done_cnt;
    current_node = IW'(u);
    start        = 1'b1;
    edges        = 0;
    do begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      start = 1'b0;
      if (poke && edges == 4) begin
        start        = 1'b1;
        current_node = IW'(3);
      end
    end while (!done && edges < 2000);
    seen  = done;
    start = 1'b0;
    check_eq("pass_done_seen", seen, 1);
    check_eq("pass_latency", edges, 2 + lat_sum + 2 * N);
    @(negedge clock);
    check_eq("pass_done_pulse", done, 0);
    check_eq("pass_done_count", done_cnt - d0, 1);
    check_eq("pass_queries_left", exp_q.size(), 0);
  endtask

  task automatic check_entry(input int i, input logic [VW-1:0] d, input logic [IW-1:0] p,
                             input logic vis);
    rd_node = IW'(i);
    #1;
    check_eq($sformatf("dist[%0d]", i), rd_dist, d);
    check_eq($sformatf("prev[%0d]", i), rd_prev, p);
    check_eq($sformatf("visited[%0d]", i), rd_visited, vis);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int base;
    int budget;
    init = 0; start = 0; source_node = '0; number_of_nodes = '0;
    current_node = '0; rd_node = '0; reset = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_qe", query_enable, 0);
    check_eq("rst_from", from_node, 0);
    check_eq("rst_to", to_node, 0);
    check_eq("rst_state", fsm_state, ST_IDLE);
    reset = 1'b0;
    @(negedge clock);

    // init from source 0
    do_init(0, N, N + 1);
    check_entry(0, 16'h0, 0, 0);
    for (int i = 1; i < N; i++) check_entry(i, INF, IW'(i), 0);

    // relax from node 0; a mid-pass start must be ignored
    do_start(0, 1'b1);
    check_entry(0, 16'd0, 0, 1);
    check_entry(1, 16'd2, 0, 0);
    check_entry(2, 16'd3, 0, 0);
    check_entry(3, 16'd4, 0, 0);

    // relax from node 1: every candidate sum is larger, so nothing changes
    do_start(1, 1'b0);
    check_entry(1, 16'd2, 0, 1);
    check_entry(2, 16'd3, 0, 0);
    check_entry(3, 16'd4, 0, 0);

    // edge (0,2) absent
    zero_mode = 1'b1;
    do_init(0, N, N + 1);
    do_start(0, 1'b0);
    zero_mode = 1'b0;
    check_entry(1, 16'd2, 0, 0);
    check_entry(2, INF, 2, 0);
    check_entry(3, 16'd4, 0, 0);

    // saturation: dist[1] = FFFE, then every sum through node 1 saturates
    sat_mode = 1'b1;
    do_init(0, N, N + 1);
    do_start(0, 1'b0);
    check_entry(1, 16'hFFFE, 0, 0);
    do_start(1, 1'b0);
    sat_mode = 1'b0;
    check_entry(1, 16'hFFFE, 0, 1);
    check_entry(2, 16'd3, 0, 0);
    check_entry(3, 16'd4, 0, 0);

    // reset while waiting on EdgeCache
    do_init(0, N, N + 1);
    exp_q.push_back({IW'(2), IW'(0)});
    current_node = IW'(2);
    start  = 1'b1;
    budget = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      budget++;
    end while (fsm_state != ST_WAIT && budget < 50);
    check_eq("reached_wait", fsm_state, ST_WAIT);
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_qe", query_enable, 0);
    check_eq("midrst_from", from_node, 0);
    check_eq("midrst_to", to_node, 0);
    check_eq("midrst_state", fsm_state, ST_IDLE);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check_entry(0, 16'd0, 0, 0);
    check_entry(2, INF, 2, 1);

    // init issued during a relax pass aborts it
    do_init(0, N, N + 1);
    for (int v = 0; v < N; v++) exp_q.push_back({IW'(0), IW'(v)});
    base         = hs_cnt;
    current_node = IW'(0);
    start        = 1'b1;
    budget       = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      budget++;
    end while (hs_cnt - base < 2 && budget < 200);
    check_eq("abort_two_queries", hs_cnt - base, 2);
    exp_q.delete();
    do_init(2, N, N + 1);
    check_entry(0, INF, 0, 0);
    check_entry(1, INF, 1, 0);
    check_entry(2, 16'd0, 2, 0);
    check_entry(3, INF, 3, 0);

    // node count 0 behaves as 1: only entry 0 is rewritten
    do_init(1, 0, 2);
    check_entry(0, INF, 0, 0);
    check_entry(2, 16'd0, 2, 0);

    repeat (10) @(negedge clock);
    check_eq("stray_queries", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
